flash_audio_reader: RTL

FLASH_AUDIO_READER -- requirements
Module: flash_audio_reader

---
 rtl/flash_audio_pkg.sv | 25 ++
 rtl/flash_audio_reader.sv | 136 +++++++++++++
 2 files changed

// File: rtl/flash_audio_pkg.sv
// Shared types and defaults for the flash audio sample reader.
// Holds the FSM encoding, parameter defaults and the overrun-state predicate.
`timescale 1ns/1ps
package flash_audio_pkg;

   localparam int DEFAULT_ADDR_W   = 23;
   localparam int DEFAULT_SAMPLE_W = 16;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      REQ        = 3'd1,
      WAIT_DATA  = 3'd2,
      OUT_FIRST  = 3'd3,
      HOLD       = 3'd4,
      OUT_SECOND = 3'd5,
      ADVANCE    = 3'd6
   } state_t;

   // States where the reader cannot accept a new sample tick, so a play tick is lost.
   function automatic logic tick_overruns(input state_t s);
      return (s == REQ) || (s == WAIT_DATA) || (s == OUT_FIRST) ||
             (s == OUT_SECOND) || (s == ADVANCE);
   endfunction

endpackage

// File: rtl/flash_audio_reader.sv
// Fetches one 2-sample word from flash per pair of sample ticks and plays its halves
// in forward or backward order, then pulses the address generator for the next word.
`timescale 1ns/1ps
module flash_audio_reader
   import flash_audio_pkg::*;
#(
   parameter int ADDR_W   = DEFAULT_ADDR_W,
   parameter int SAMPLE_W = DEFAULT_SAMPLE_W
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  sample_tick,
   input  logic [1:0]            direction,
   input  logic [ADDR_W-1:0]     address,
   output logic                  advance,
   output logic                  flash_read,
   output logic [ADDR_W-1:0]     flash_address,
   input  logic                  flash_waitrequest,
   input  logic [2*SAMPLE_W-1:0] flash_readdata,
   input  logic                  flash_readdatavalid,
   output logic [SAMPLE_W-1:0]   audio_data,
   output logic                  audio_valid,
   output logic                  overrun
);

   localparam int WORD_W = 2 * SAMPLE_W;

   state_t              state_reg,       state_next;
   logic [ADDR_W-1:0]   addr_reg,        addr_next;
   logic                backward_reg,    backward_next;
   logic [WORD_W-1:0]   word_reg,        word_next;
   logic [SAMPLE_W-1:0] audio_data_reg,  audio_data_next;
   logic                audio_valid_reg, audio_valid_next;
   logic                advance_reg,     advance_next;
   logic                flash_read_reg,  flash_read_next;
   logic                overrun_reg,     overrun_next;

   logic play_tick;
   logic [SAMPLE_W-1:0] rd_lo, rd_hi, word_lo, word_hi;

   assign play_tick = sample_tick && direction[1];
   assign rd_lo     = flash_readdata[SAMPLE_W-1:0];
   assign rd_hi     = flash_readdata[WORD_W-1:SAMPLE_W];
   assign word_lo   = word_reg[SAMPLE_W-1:0];
   assign word_hi   = word_reg[WORD_W-1:SAMPLE_W];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg       <= IDLE;
         addr_reg        <= '0;
         backward_reg    <= 1'b0;
         word_reg        <= '0;
         audio_data_reg  <= '0;
         audio_valid_reg <= 1'b0;
         advance_reg     <= 1'b0;
         flash_read_reg  <= 1'b0;
         overrun_reg     <= 1'b0;
      end else begin
         state_reg       <= state_next;
         addr_reg        <= addr_next;
         backward_reg    <= backward_next;
         word_reg        <= word_next;
         audio_data_reg  <= audio_data_next;
         audio_valid_reg <= audio_valid_next;
         advance_reg     <= advance_next;
         flash_read_reg  <= flash_read_next;
         overrun_reg     <= overrun_next;
      end
   end

   // Outputs are computed from the next state so every registered output
   // appears exactly one cycle after the input event that causes it.
   always_comb begin
      state_next       = state_reg;
      addr_next        = addr_reg;
      backward_next    = backward_reg;
      word_next        = word_reg;
      audio_data_next  = audio_data_reg;
      audio_valid_next = 1'b0;
      advance_next     = 1'b0;
      overrun_next     = overrun_reg || (play_tick && tick_overruns(state_reg));

      case (state_reg)
         IDLE: begin
            if (play_tick) begin
               state_next    = REQ;
               addr_next     = address;
               backward_next = direction[0];
            end
         end
         REQ: begin
            if (!flash_waitrequest) begin
               state_next = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            if (flash_readdatavalid) begin
               state_next       = OUT_FIRST;
               word_next        = flash_readdata;
               audio_valid_next = 1'b1;
               audio_data_next  = backward_reg ? rd_hi : rd_lo;
            end
         end
         OUT_FIRST: begin
            state_next = HOLD;
         end
         HOLD: begin
            if (play_tick) begin
               state_next       = OUT_SECOND;
               audio_valid_next = 1'b1;
               audio_data_next  = backward_reg ? word_lo : word_hi;
            end
         end
         OUT_SECOND: begin
            state_next   = ADVANCE;
            advance_next = 1'b1;
         end
         ADVANCE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      flash_read_next = (state_next == REQ);
   end

   assign advance       = advance_reg;
   assign flash_read    = flash_read_reg;
   assign flash_address = addr_reg;
   assign audio_data    = audio_data_reg;
   assign audio_valid   = audio_valid_reg;
   assign overrun       = overrun_reg;

endmodule
